// File: rtl/pasc_top_if.sv
// Output port bundle of the PASC cluster: the registered store-to-output port
// plus a flat view of every core's FSM state for observation.
interface pasc_top_if #(
    parameter int NUM_CORES = 4
);
    logic [15:0]            output_data_val;
    logic                   output_enable;
    logic [3*NUM_CORES-1:0] core_state;

    modport master (
        output output_data_val,
        output output_enable,
        output core_state
    );

    modport slave (
        input output_data_val,
        input output_enable,
        input core_state
    );
endinterface

// File: rtl/pasc_top.sv
// PASC multicore array: tiny 16-bit accumulator cores sharing one synchronous
// single-port word memory through a round-robin arbiter, with a store-mapped output port.

module pasc_memory #(
    parameter int          MEM_WORDS   = 4096,
    parameter logic [11:0] OUTPUT_ADDR = 12'hFFF
) (
    input  logic        clk,
    input  logic [11:0] addr,
    input  logic        we,
    input  logic [15:0] wdata,
    output logic [15:0] rdata
);
    // Not reset: the program image is preloaded before reset is released.
    logic [15:0] data [0:MEM_WORDS-1];

    always_ff @(posedge clk) begin
        if (we) begin
            data[addr] <= wdata;
        end
        rdata <= (addr == OUTPUT_ADDR) ? 16'h0000 : data[addr];
    end
endmodule

module pasc_core #(
    parameter int CORE_ID = 0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        gnt,
    input  logic [15:0] rdata,
    output logic        req,
    output logic        we,
    output logic [11:0] addr,
    output logic [15:0] wdata,
    output logic [2:0]  state_dbg
);
    typedef enum logic [2:0] {
        S_FETCH      = 3'd0,
        S_FETCH_WAIT = 3'd1,
        S_EXEC       = 3'd2,
        S_LOAD_WAIT  = 3'd3,
        S_HALTED     = 3'd4
    } state_t;

    localparam logic [3:0] OP_LDA  = 4'h0;
    localparam logic [3:0] OP_STA  = 4'h1;
    localparam logic [3:0] OP_ADD  = 4'h2;
    localparam logic [3:0] OP_SUB  = 4'h3;
    localparam logic [3:0] OP_AND  = 4'h4;
    localparam logic [3:0] OP_LDI  = 4'h5;
    localparam logic [3:0] OP_JMP  = 4'h6;
    localparam logic [3:0] OP_JZ   = 4'h7;
    localparam logic [3:0] OP_JNEG = 4'h8;
    localparam logic [3:0] OP_CID  = 4'h9;
    localparam logic [3:0] OP_HALT = 4'hA;
    localparam logic [15:0] CID_VAL = 16'(CORE_ID);

    state_t      state, state_nxt;
    logic [11:0] pc, pc_nxt;
    logic [15:0] acc, acc_nxt;
    logic [15:0] ir, ir_nxt;
    logic [3:0]  opcode;
    logic [11:0] operand;

    assign opcode    = ir[15:12];
    assign operand   = ir[11:0];
    assign state_dbg = state;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_FETCH;
            pc    <= '0;
            acc   <= '0;
            ir    <= '0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            acc   <= acc_nxt;
            ir    <= ir_nxt;
        end
    end

    // Request handshake: req is held with stable addr/we/wdata until gnt; the
    // transfer happens on the rising edge where req && gnt, and read data
    // appears on rdata during the following cycle.
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        acc_nxt   = acc;
        ir_nxt    = ir;
        req       = 1'b0;
        we        = 1'b0;
        addr      = pc;
        wdata     = acc;
        case (state)
            S_FETCH: begin
                req = 1'b1;
                if (gnt) state_nxt = S_FETCH_WAIT;
            end
            S_FETCH_WAIT: begin
                ir_nxt    = rdata;
                pc_nxt    = pc + 12'd1;
                state_nxt = S_EXEC;
            end
            S_EXEC: begin
                state_nxt = S_FETCH;
                case (opcode)
                    OP_LDA, OP_ADD, OP_SUB, OP_AND: begin
                        req       = 1'b1;
                        addr      = operand;
                        state_nxt = gnt ? S_LOAD_WAIT : S_EXEC;
                    end
                    OP_STA: begin
                        req       = 1'b1;
                        we        = 1'b1;
                        addr      = operand;
                        state_nxt = gnt ? S_FETCH : S_EXEC;
                    end
                    OP_LDI:  acc_nxt = {4'h0, operand};
                    OP_JMP:  pc_nxt  = operand;
                    OP_JZ:   if (acc == 16'h0000) pc_nxt = operand;
                    OP_JNEG: if (acc[15]) pc_nxt = operand;
                    OP_CID:  acc_nxt = CID_VAL;
                    OP_HALT: state_nxt = S_HALTED;
                    default: state_nxt = S_FETCH;
                endcase
            end
            S_LOAD_WAIT: begin
                state_nxt = S_FETCH;
                case (opcode)
                    OP_LDA:  acc_nxt = rdata;
                    OP_ADD:  acc_nxt = acc + rdata;
                    OP_SUB:  acc_nxt = acc - rdata;
                    OP_AND:  acc_nxt = acc & rdata;
                    default: acc_nxt = acc;
                endcase
            end
            S_HALTED: state_nxt = S_HALTED;
            default:  state_nxt = S_FETCH;
        endcase
    end
endmodule

module pasc_cluster #(
    parameter int          NUM_CORES   = 4,
    parameter int          MEM_WORDS   = 4096,
    parameter logic [11:0] OUTPUT_ADDR = 12'hFFF
) (
    input  logic                   clk,
    input  logic                   reset_n,
    output logic [15:0]            output_data_val,
    output logic                   output_enable,
    output logic [3*NUM_CORES-1:0] core_state
);
    localparam int IW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

    logic [NUM_CORES-1:0] core_req, core_we, gnt;
    logic [11:0]          core_addr  [NUM_CORES];
    logic [15:0]          core_wdata [NUM_CORES];
    logic [IW-1:0]        ptr, gnt_idx, ptr_nxt;
    logic                 gnt_any;
    logic [11:0]          mem_addr;
    logic [15:0]          mem_wdata, mem_rdata;
    logic                 mem_we, out_hit;

    for (genvar i = 0; i < NUM_CORES; i++) begin : g_core
        pasc_core #(.CORE_ID(i)) core (
            .clk       (clk),
            .reset_n   (reset_n),
            .gnt       (gnt[i]),
            .rdata     (mem_rdata),
            .req       (core_req[i]),
            .we        (core_we[i]),
            .addr      (core_addr[i]),
            .wdata     (core_wdata[i]),
            .state_dbg (core_state[3*i +: 3])
        );
    end

    // Round-robin: first requester found searching upward from ptr wins.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        gnt     = '0;
        for (int k = 0; k < NUM_CORES; k++) begin
            if (!gnt_any && core_req[(int'(ptr) + k) % NUM_CORES]) begin
                gnt_any = 1'b1;
                gnt_idx = IW'((int'(ptr) + k) % NUM_CORES);
            end
        end
        if (gnt_any) gnt[gnt_idx] = 1'b1;
    end

    assign ptr_nxt   = (gnt_idx == IW'(NUM_CORES - 1)) ? '0 : gnt_idx + 1'b1;
    assign mem_addr  = core_addr[gnt_idx];
    assign mem_wdata = core_wdata[gnt_idx];
    assign mem_we    = gnt_any && core_we[gnt_idx];
    assign out_hit   = mem_we && (mem_addr == OUTPUT_ADDR);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr             <= '0;
            output_enable   <= 1'b0;
            output_data_val <= 16'h0000;
        end else begin
            if (gnt_any) ptr <= ptr_nxt;
            output_enable <= out_hit;
            if (out_hit) output_data_val <= mem_wdata;
        end
    end

    pasc_memory #(
        .MEM_WORDS   (MEM_WORDS),
        .OUTPUT_ADDR (OUTPUT_ADDR)
    ) global_memory (
        .clk   (clk),
        .addr  (mem_addr),
        .we    (mem_we && !out_hit),
        .wdata (mem_wdata),
        .rdata (mem_rdata)
    );
endmodule

module pasc_top #(
    parameter int          NUM_CORES   = 4,
    parameter int          MEM_WORDS   = 4096,
    parameter logic [11:0] OUTPUT_ADDR = 12'hFFF
) (
    input  logic       clk,
    input  logic       reset_n,
    pasc_top_if.master out_port
);
    pasc_cluster #(
        .NUM_CORES   (NUM_CORES),
        .MEM_WORDS   (MEM_WORDS),
        .OUTPUT_ADDR (OUTPUT_ADDR)
    ) cluster (
        .clk             (clk),
        .reset_n         (reset_n),
        .output_data_val (out_port.output_data_val),
        .output_enable   (out_port.output_enable),
        .core_state      (out_port.core_state)
    );
endmodule

// File: tb/tb_pasc_top.sv
// Bench for pasc_top: a 1-core and a 4-core instance run small preloaded
// programs; output strobes are scored against expected-value queues.
module tb_pasc_top;
    logic clk = 1'b0;
    logic rst1_n = 1'b1;
    logic rst4_n = 1'b1;
    always #5 clk = ~clk;

    pasc_top_if #(.NUM_CORES(1)) o1 ();
    pasc_top_if #(.NUM_CORES(4)) o4 ();

    pasc_top #(.NUM_CORES(1)) d1 (.clk(clk), .reset_n(rst1_n), .out_port(o1));
    pasc_top #(.NUM_CORES(4)) d4 (.clk(clk), .reset_n(rst4_n), .out_port(o4));

    int checks = 0;
    int errors = 0;
    logic [15:0] exp1_q[$];
    logic [15:0] exp4_q[$];
    bit fair_mode = 1'b0;
    int fair_cnt[4];

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Scoreboard monitors
    always @(negedge clk) begin
        if (o1.output_enable === 1'b1) begin
            if (exp1_q.size() == 0) begin
                checks++;
                assert (exp1_q.size() != 0) else begin
                    errors++;
                    $error("FAIL d1_extra_strobe got=%h exp=none", o1.output_data_val);
                end
            end else begin
                check("d1_out", o1.output_data_val, exp1_q.pop_front());
            end
        end
        if (o4.output_enable === 1'b1) begin
            if (fair_mode) begin
                check("d4_fair_idx", 16'(o4.output_data_val < 16'd4), 16'd1);
                fair_cnt[o4.output_data_val[1:0]]++;
            end else if (exp4_q.size() == 0) begin
                checks++;
                assert (exp4_q.size() != 0) else begin
                    errors++;
                    $error("FAIL d4_extra_strobe got=%h exp=none", o4.output_data_val);
                end
            end else begin
                check("d4_out", o4.output_data_val, exp4_q.pop_front());
            end
        end
    end

    task automatic clear1();
        for (int i = 0; i < 4096; i++) d1.cluster.global_memory.data[i] = 16'h0000;
    endtask
    task automatic poke1(input int a, input logic [15:0] v);
        d1.cluster.global_memory.data[a] = v;
    endtask
    task automatic clear4();
        for (int i = 0; i < 4096; i++) d4.cluster.global_memory.data[i] = 16'h0000;
    endtask
    task automatic poke4(input int a, input logic [15:0] v);
        d4.cluster.global_memory.data[a] = v;
    endtask

    task automatic drain1(input string tag, input int budget);
        int n = 0;
        while (exp1_q.size() != 0 && n < budget) begin
            @(negedge clk); #1;
            n++;
        end
        check(tag, 16'(exp1_q.size()), 16'd0);
    endtask
    task automatic drain4(input string tag, input int budget);
        int n = 0;
        while (exp4_q.size() != 0 && n < budget) begin
            @(negedge clk); #1;
            n++;
        end
        check(tag, 16'(exp4_q.size()), 16'd0);
    endtask

    task automatic countdown1();
        poke1(0, 16'h5003);  // LDI 3
        poke1(1, 16'h1FFF);  // STA out
        poke1(2, 16'h3020);  // SUB one
        poke1(3, 16'h7005);  // JZ halt
        poke1(4, 16'h6001);  // JMP loop
        poke1(5, 16'hA000);  // HALT
        poke1(16'h20, 16'h0001);
    endtask

    initial begin
        int mx, mn;
        // Reset
        #2;
        rst1_n = 1'b0;
        rst4_n = 1'b0;
        @(negedge clk); #1;
        check("rst_d1_val", o1.output_data_val, 16'h0000);
        check("rst_d1_en", 16'(o1.output_enable), 16'd0);
        check("rst_d1_state", 16'(o1.core_state), 16'h0000);
        check("rst_d4_val", o4.output_data_val, 16'h0000);
        check("rst_d4_en", 16'(o4.output_enable), 16'd0);
        check("rst_d4_state", 16'(o4.core_state), 16'h0000);

        // Single core LDI/STA/HALT with exact strobe timing
        clear1();
        poke1(0, 16'h5041); poke1(1, 16'h1FFF); poke1(2, 16'hA000);
        exp1_q.push_back(16'h0041);
        @(negedge clk);
        rst1_n = 1'b1;
        repeat (5) @(posedge clk);
        #1 check("t1_no_early_strobe", 16'(o1.output_enable), 16'd0);
        @(posedge clk);
        #1 check("t1_strobe_at_edge6", 16'(o1.output_enable), 16'd1);
        check("t1_value_at_edge6", o1.output_data_val, 16'h0041);
        @(posedge clk);
        #1 check("t1_strobe_one_cycle", 16'(o1.output_enable), 16'd0);
        drain1("t1_drain", 50);
        repeat (30) @(negedge clk);
        check("t1_halted", 16'(o1.core_state), 16'h0004);
        check("t1_hold", o1.output_data_val, 16'h0041);

        // Wraparound add
        @(negedge clk); #2 rst1_n = 1'b0;
        clear1();
        poke1(0, 16'h5001); poke1(1, 16'h2010); poke1(2, 16'h1FFF); poke1(3, 16'hA000);
        poke1(16'h10, 16'hFFFF);
        exp1_q.push_back(16'h0000);
        @(negedge clk);
        rst1_n = 1'b1;
        drain1("t3_drain", 100);
        repeat (20) @(negedge clk);
        check("t3_halted", 16'(o1.core_state), 16'h0004);

        // Countdown loop
        @(negedge clk); #2 rst1_n = 1'b0;
        clear1();
        countdown1();
        exp1_q.push_back(16'd3); exp1_q.push_back(16'd2); exp1_q.push_back(16'd1);
        @(negedge clk);
        rst1_n = 1'b1;
        drain1("t4_drain", 300);
        repeat (30) @(negedge clk);
        check("t4_hold_last", o1.output_data_val, 16'd1);
        check("t4_en_idle", 16'(o1.output_enable), 16'd0);
        check("t4_halted", 16'(o1.core_state), 16'h0004);

        // Reset mid-program restarts the sequence
        @(negedge clk); #2 rst1_n = 1'b0;
        exp1_q.push_back(16'd3);
        @(negedge clk);
        rst1_n = 1'b1;
        drain1("t6_first_drain", 100);
        #1 rst1_n = 1'b0;
        #1 check("t6_rst_val", o1.output_data_val, 16'h0000);
        check("t6_rst_en", 16'(o1.output_enable), 16'd0);
        check("t6_rst_state", 16'(o1.core_state), 16'h0000);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("t6_rst_held_val", o1.output_data_val, 16'h0000);
        exp1_q.push_back(16'd3); exp1_q.push_back(16'd2); exp1_q.push_back(16'd1);
        rst1_n = 1'b1;
        drain1("t6_restart_drain", 300);
        repeat (30) @(negedge clk);
        check("t6_halted", 16'(o1.core_state), 16'h0004);

        // Four cores: CID then store, outputs in core order
        clear4();
        poke4(0, 16'h9000); poke4(1, 16'h1FFF); poke4(2, 16'hA000);
        for (int i = 0; i < 4; i++) exp4_q.push_back(16'(i));
        @(negedge clk);
        rst4_n = 1'b1;
        drain4("t2_drain", 200);
        repeat (30) @(negedge clk);
        check("t2_all_halted", 16'(o4.core_state), 16'h0924);
        check("t2_hold_last", o4.output_data_val, 16'd3);

        // Fairness: every core loops storing its index
        @(negedge clk); #2 rst4_n = 1'b0;
        clear4();
        poke4(0, 16'h9000); poke4(1, 16'h1FFF); poke4(2, 16'h6001);
        for (int i = 0; i < 4; i++) fair_cnt[i] = 0;
        fair_mode = 1'b1;
        @(negedge clk);
        rst4_n = 1'b1;
        repeat (300) @(negedge clk);
        #1 rst4_n = 1'b0;
        fair_mode = 1'b0;
        mx = fair_cnt[0];
        mn = fair_cnt[0];
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t5_core%0d_served", i), 16'(fair_cnt[i] >= 10), 16'd1);
            if (fair_cnt[i] > mx) mx = fair_cnt[i];
            if (fair_cnt[i] < mn) mn = fair_cnt[i];
        end
        check("t5_balance", 16'((mx - mn) <= 3), 16'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog_timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end
endmodule
